pcs_tx_scrambler: RTL

Transmit PCS stage between the 64b/66b encoder and the TX gearbox. It accepts encoded words with their sync header and scrambles the payload with the self-synchronizing x^58+x^39+1 polynomial. It generates the sequence count that drives the gearbox and withholds input during the gearbox flush cycle. On upstream underflow it substitutes an idle block.

---
 rtl/pcs_tx_scrambler.sv | 136 +++++++++++++
 1 files changed

// File: rtl/pcs_tx_scrambler.sv
// 64b/66b transmit PCS stage: self-synchronizing x^58+x^39+1 payload scrambler, gearbox
// sequence generation with a one-cycle flush stall, and idle-block substitution on underflow.
module pcs_tx_scrambler #(
    parameter int DATA_W       = 64,
    parameter int BLOCK_DATA_W = 64,
    parameter int HEAD_W       = 2,
    parameter int SEQ_FULL     = DATA_W / HEAD_W,
    parameter int SEQ_W        = $clog2(DATA_W / HEAD_W + 1)
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [HEAD_W-1:0] head_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              bypass_i,
    output logic [SEQ_W-1:0]  seq_o,
    output logic              head_v_o,
    output logic [HEAD_W-1:0] head_o,
    output logic [DATA_W-1:0] data_o,
    output logic              underflow_o
);
    localparam int CNT_N = BLOCK_DATA_W / DATA_W;
    localparam int CNT_W = (CNT_N > 1) ? $clog2(CNT_N) : 1;
    localparam int SCR_W = 58;
    localparam int TAP_A = 39;

    localparam logic [SEQ_W-1:0]  SEQ_LAST  = SEQ_W'(SEQ_FULL - 1);
    localparam logic [SEQ_W-1:0]  SEQ_FLUSH = SEQ_W'(SEQ_FULL);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CNT_N - 1);
    localparam logic [HEAD_W-1:0] IDLE_HEAD = HEAD_W'(2'b10);
    localparam logic [DATA_W-1:0] IDLE_WORD = DATA_W'(8'h1E);

    // cnt_reg/seq_reg describe the word currently presented on data_o; the word being
    // accepted this cycle gets word_idx/word_seq.
    logic [SEQ_W-1:0]  seq_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              idle_reg;
    logic [SCR_W-1:0]  scr_reg;
    logic [DATA_W-1:0] data_reg;
    logic [HEAD_W-1:0] head_reg;
    logic              head_v_reg;
    logic              underflow_reg;

    logic                    slot;
    logic                    from_flush;
    logic                    block_end;
    logic [CNT_W-1:0]        word_idx;
    logic [SEQ_W-1:0]        word_seq;
    logic                    first_word;
    logic                    idle_word;
    logic [DATA_W-1:0]       raw_word;
    logic [SCR_W+DATA_W-1:0] scr_ext;
    logic [DATA_W-1:0]       scr_word;

    assign slot       = !(seq_reg == SEQ_LAST && cnt_reg == CNT_LAST && seq_reg != SEQ_FLUSH);
    assign from_flush = (seq_reg == SEQ_FLUSH);
    assign block_end  = (cnt_reg == CNT_LAST);

    // Leaving the flush state (or reset) always starts a fresh block at sequence 0.
    always_comb begin
        word_idx = '0;
        word_seq = '0;
        if (from_flush) begin
            word_idx = '0;
            word_seq = '0;
        end else if (block_end) begin
            word_idx = '0;
            word_seq = seq_reg + SEQ_W'(1);
        end else begin
            word_idx = cnt_reg + CNT_W'(1);
            word_seq = seq_reg;
        end
    end

    assign first_word = (word_idx == '0);
    assign idle_word  = first_word ? !in_valid_i : idle_reg;

    always_comb begin
        raw_word = '0;
        if (idle_word) begin
            raw_word = first_word ? IDLE_WORD : '0;
        end else if (in_valid_i) begin
            raw_word = data_i;
        end
    end

    // Low SCR_W bits of scr_ext are the transmitted history (bit SCR_W-1 most recent);
    // each new bit may depend on bits produced earlier in the same word.
    always_comb begin
        scr_ext = '0;
        scr_ext[SCR_W-1:0] = scr_reg;
        for (int n = 0; n < DATA_W; n++) begin
            scr_ext[SCR_W + n] = raw_word[n] ^ scr_ext[SCR_W + n - TAP_A] ^ scr_ext[n];
        end
    end

    assign scr_word = scr_ext[SCR_W +: DATA_W];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            seq_reg       <= SEQ_FLUSH;
            cnt_reg       <= '0;
            idle_reg      <= 1'b0;
            scr_reg       <= '1;
            data_reg      <= '0;
            head_reg      <= '0;
            head_v_reg    <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (slot) begin
            seq_reg    <= word_seq;
            cnt_reg    <= word_idx;
            idle_reg   <= idle_word;
            scr_reg    <= scr_ext[DATA_W +: SCR_W];
            data_reg   <= bypass_i ? raw_word : scr_word;
            head_v_reg <= first_word;
            if (first_word) begin
                head_reg <= idle_word ? IDLE_HEAD : head_i;
            end
            if (!in_valid_i) begin
                underflow_reg <= 1'b1;
            end
        end else begin
            seq_reg    <= SEQ_FLUSH;
            head_v_reg <= 1'b0;
        end
    end

    assign in_ready_o  = slot;
    assign seq_o       = seq_reg;
    assign head_v_o    = head_v_reg;
    assign head_o      = head_reg;
    assign data_o      = data_reg;
    assign underflow_o = underflow_reg;

endmodule
